// File: rtl/sim_mcb_port.sv
// Behavioural single-port memory controller model: command/write/read FIFOs feeding a delayed executor over a backing RAM.
// Optional macro SIM_MCB_PORT_STALL_EN makes reads stall on a full read FIFO instead of discarding words.
module sim_mcb_port #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 64,
    parameter int CMD_DEPTH      = 4,
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int CMD_DELAY      = 20,
    parameter int CAL_DELAY      = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    calibration_done,
    input  logic                    cmd_en,
    input  logic [2:0]              cmd_instr,
    input  logic [5:0]              cmd_bl,
    input  logic [29:0]             cmd_byte_addr,
    output logic                    cmd_empty,
    output logic                    cmd_full,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH/8-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_full,
    output logic                    wr_empty,
    output logic                    wr_underrun,
    output logic                    wr_error,
    output logic [6:0]              wr_count,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_full,
    output logic                    rd_empty,
    output logic                    rd_overflow,
    output logic                    rd_error,
    output logic [6:0]              rd_count
);

    // state | meaning
    // IDLE  | waiting for calibration and a queued command
    // DELAY | command popped, counting CMD_DELAY cycles
    // WRITE | one wr FIFO word to memory per cycle, stalls when empty
    // READ  | one memory word to rd FIFO per cycle
    // NOP   | single idle cycle for unsupported instructions

    localparam int NB   = DATA_WIDTH / 8;
    localparam int BSH  = $clog2(NB);
    localparam int AW   = MEM_WORDS_LOG2;
    localparam int FPW  = $clog2(FIFO_DEPTH);
    localparam int CPW  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CCW  = $clog2(CMD_DEPTH + 1);
    localparam int DLW  = (CMD_DELAY > 0) ? $clog2(CMD_DELAY + 1) : 1;
    localparam int CLW  = (CAL_DELAY > 0) ? $clog2(CAL_DELAY + 1) : 1;

    typedef enum logic [2:0] {IDLE, DELAY, WRITE, READ, NOP} state_t;

    state_t state, nxt;

    // calibration
    logic [CLW-1:0] cal_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cal_cnt <= CLW'(CAL_DELAY);
        else if (cal_cnt != '0)
            cal_cnt <= cal_cnt - CLW'(1);
    end

    assign calibration_done = (cal_cnt == '0);

    // command FIFO (word address is extracted at push time)
    logic [2:0]     cq_instr [CMD_DEPTH];
    logic [5:0]     cq_bl    [CMD_DEPTH];
    logic [AW-1:0]  cq_addr  [CMD_DEPTH];
    logic [CPW-1:0] cq_wptr, cq_rptr;
    logic [CCW-1:0] cq_cnt;
    logic           cmd_push, cmd_pop;
    logic           addr_unused;

    assign addr_unused = ^cmd_byte_addr;
    assign cmd_full  = (cq_cnt == CCW'(CMD_DEPTH));
    assign cmd_empty = (cq_cnt == '0);
    assign cmd_push  = cmd_en && !cmd_full;

    function automatic logic [CPW-1:0] cptr_next(input logic [CPW-1:0] p);
        return (p == CPW'(CMD_DEPTH - 1)) ? '0 : p + CPW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cq_instr[cq_wptr] <= cmd_instr;
            cq_bl[cq_wptr]    <= cmd_bl;
            cq_addr[cq_wptr]  <= AW'(cmd_byte_addr >> BSH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cq_wptr <= '0;
            cq_rptr <= '0;
            cq_cnt  <= '0;
        end else begin
            if (cmd_push) cq_wptr <= cptr_next(cq_wptr);
            if (cmd_pop)  cq_rptr <= cptr_next(cq_rptr);
            if (cmd_push && !cmd_pop)
                cq_cnt <= cq_cnt + CCW'(1);
            else if (!cmd_push && cmd_pop)
                cq_cnt <= cq_cnt - CCW'(1);
        end
    end

    // write FIFO
    logic [DATA_WIDTH-1:0] wq_data [FIFO_DEPTH];
    logic [NB-1:0]         wq_mask [FIFO_DEPTH];
    logic [FPW-1:0]        wq_wptr, wq_rptr;
    logic [6:0]            wq_cnt;
    logic                  wr_push, wr_pop;
    logic                  wr_error_q, wr_underrun_q, underrun_set;

    assign wr_full     = (wq_cnt == 7'(FIFO_DEPTH));
    assign wr_empty    = (wq_cnt == '0);
    assign wr_count    = wq_cnt;
    assign wr_push     = wr_en && !wr_full;
    assign wr_error    = wr_error_q;
    assign wr_underrun = wr_underrun_q;

    always_ff @(posedge clk) begin
        if (wr_push) begin
            wq_data[wq_wptr] <= wr_data;
            wq_mask[wq_wptr] <= wr_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wq_wptr       <= '0;
            wq_rptr       <= '0;
            wq_cnt        <= '0;
            wr_error_q    <= 1'b0;
            wr_underrun_q <= 1'b0;
        end else begin
            if (wr_push) wq_wptr <= wq_wptr + FPW'(1);
            if (wr_pop)  wq_rptr <= wq_rptr + FPW'(1);
            if (wr_push && !wr_pop)
                wq_cnt <= wq_cnt + 7'd1;
            else if (!wr_push && wr_pop)
                wq_cnt <= wq_cnt - 7'd1;
            if (wr_en && wr_full) wr_error_q <= 1'b1;
            if (underrun_set)     wr_underrun_q <= 1'b1;
        end
    end

    // read FIFO
    logic [DATA_WIDTH-1:0] rq_data [FIFO_DEPTH];
    logic [FPW-1:0]        rq_wptr, rq_rptr;
    logic [6:0]            rq_cnt;
    logic                  rd_push, rd_pop;
    logic                  rd_error_q, rd_overflow_q, overflow_set;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign rd_full     = (rq_cnt == 7'(FIFO_DEPTH));
    assign rd_empty    = (rq_cnt == '0);
    assign rd_count    = rq_cnt;
    assign rd_pop      = rd_en && !rd_empty;
    assign rd_error    = rd_error_q;
    assign rd_overflow = rd_overflow_q;

    always_ff @(posedge clk) begin
        if (rd_push)
            rq_data[rq_wptr] <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rq_wptr       <= '0;
            rq_rptr       <= '0;
            rq_cnt        <= '0;
            rd_data       <= '0;
            rd_error_q    <= 1'b0;
            rd_overflow_q <= 1'b0;
        end else begin
            if (rd_push) rq_wptr <= rq_wptr + FPW'(1);
            if (rd_pop) begin
                rq_rptr <= rq_rptr + FPW'(1);
                rd_data <= rq_data[rq_rptr];
            end
            if (rd_push && !rd_pop)
                rq_cnt <= rq_cnt + 7'd1;
            else if (!rd_push && rd_pop)
                rq_cnt <= rq_cnt - 7'd1;
            if (rd_en && rd_empty) rd_error_q <= 1'b1;
            if (overflow_set)      rd_overflow_q <= 1'b1;
        end
    end

    // executor
    logic [DLW-1:0] dly_cnt;
    logic [5:0]     words_left;
    logic [AW-1:0]  addr;
    logic [2:0]     cur_instr;
    logic           adv, mem_we, last_word;

    assign last_word = (words_left == '0);

    always_comb begin
        nxt          = state;
        cmd_pop      = 1'b0;
        wr_pop       = 1'b0;
        rd_push      = 1'b0;
        mem_we       = 1'b0;
        adv          = 1'b0;
        underrun_set = 1'b0;
        overflow_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (calibration_done && !cmd_empty) begin
                    cmd_pop = 1'b1;
                    nxt     = DELAY;
                end
            end
            DELAY: begin
                if (dly_cnt == DLW'(1) || dly_cnt == '0) begin
                    case (cur_instr)
                        3'b000, 3'b010: nxt = WRITE;
                        3'b001, 3'b011: nxt = READ;
                        default:        nxt = NOP;
                    endcase
                end
            end
            WRITE: begin
                if (!wr_empty) begin
                    wr_pop = 1'b1;
                    mem_we = 1'b1;
                    adv    = 1'b1;
                    if (last_word) nxt = IDLE;
                end else begin
                    underrun_set = 1'b1;
                end
            end
            READ: begin
`ifdef SIM_MCB_PORT_STALL_EN
                if (!rd_full || rd_pop) begin
                    rd_push = 1'b1;
                    adv     = 1'b1;
                    if (last_word) nxt = IDLE;
                end
`else
                adv = 1'b1;
                if (!rd_full || rd_pop)
                    rd_push = 1'b1;
                else
                    overflow_set = 1'b1;
                if (last_word) nxt = IDLE;
`endif
            end
            NOP: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dly_cnt    <= '0;
            words_left <= '0;
            addr       <= '0;
            cur_instr  <= '0;
        end else begin
            state <= nxt;
            if (cmd_pop) begin
                cur_instr  <= cq_instr[cq_rptr];
                words_left <= cq_bl[cq_rptr];
                addr       <= cq_addr[cq_rptr];
                dly_cnt    <= DLW'(CMD_DELAY);
            end else if (state == DELAY && dly_cnt != '0) begin
                dly_cnt <= dly_cnt - DLW'(1);
            end
            if (adv) begin
                addr       <= addr + AW'(1);
                words_left <= words_left - 6'd1;
            end
        end
    end

    // backing memory is never reset; a reset edge must not commit a pending word
    logic [DATA_WIDTH-1:0] mem [2**AW];

    assign mem_rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < NB; b++) begin
                if (!wq_mask[wq_rptr][b])
                    mem[addr][b*8 +: 8] <= wq_data[wq_rptr][b*8 +: 8];
            end
        end
    end

endmodule
